// File: rtl/rfid_reader_pie_tx_pkg.sv
// Shared definitions for the Gen2 reader PIE transmitter: default symbol
// timing in 128 ns clock cycles, payload width, FSM state encoding and the
// data-bit symbol length helper.
package rfid_reader_pie_tx_pkg;

  // Clock is 2^CLK_EXP ns per cycle; upstream ns->cycle conversions shift by this.
  localparam int CLK_EXP        = 7;
  localparam int MAX_BITS       = 64;
  localparam int CNT_W          = 16;

  localparam int DELIM_CYC_DEF  = 117;
  localparam int PW_CYC_DEF     = 8;
  localparam int TARI_CYC_DEF   = 49;
  localparam int RTCAL_CYC_DEF  = 146;
  localparam int TRCAL_CYC_DEF  = 195;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELIM = 3'd1,
    ST_DATA0 = 3'd2,
    ST_RTCAL = 3'd3,
    ST_TRCAL = 3'd4,
    ST_BITS  = 3'd5,
    ST_DONE  = 3'd6
  } pie_state_t;

  // A data-1 lasts RTCAL minus one Tari; a data-0 lasts one Tari.
  function automatic logic [CNT_W-1:0] bit_sym_len(input logic b, input int tari,
                                                   input int rtcal);
    return b ? CNT_W'(rtcal - tari) : CNT_W'(tari);
  endfunction

endpackage

// File: rtl/rfid_pie_symbol_timer.sv
// PIE symbol timer: loaded with a symbol length L, it holds the modulation
// level high for L-PW_CYC cycles then low for PW_CYC cycles, and flags the
// last cycle of the symbol with sym_end. A delimiter load holds the level low
// for the whole length. The level output is a flop and idles high (CW).
module rfid_pie_symbol_timer
  import rfid_reader_pie_tx_pkg::*;
#(
  parameter int PW_CYC = PW_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_len,
  input  logic             load_low,
  input  logic             force_high,
  output logic             level,
  output logic             sym_end
);

  logic [CNT_W-1:0] cnt_q;
  logic             low_only_q;
  logic [CNT_W-1:0] cnt_m1;

  // cnt_q is the number of cycles left in the current symbol, this one included.
  assign cnt_m1  = cnt_q - CNT_W'(1);
  assign sym_end = (cnt_q == CNT_W'(1));

  // Count down the active symbol and register the level for the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      low_only_q <= 1'b0;
      level      <= 1'b1;
    end else if (force_high) begin
      cnt_q      <= '0;
      low_only_q <= 1'b0;
      level      <= 1'b1;
    end else if (load) begin
      cnt_q      <= load_len;
      low_only_q <= load_low;
      level      <= !load_low && (load_len > CNT_W'(PW_CYC));
    end else if (cnt_q != '0) begin
      cnt_q      <= cnt_m1;
      level      <= !low_only_q && (cnt_m1 > CNT_W'(PW_CYC));
    end
  end

endmodule

// File: rtl/rfid_reader_pie_tx.sv
// Gen2 reader-to-tag PIE modulator. Captures a right-aligned command bit
// vector and emits delimiter, data-0, RTCAL, optional TRCAL, then the bits
// MSB first as PIE symbols on reader_modulation (1 = CW, 0 = low pulse).
// Optional feature: define PIE_TX_ABORT_EN to let tx_abort cut a packet short.
// Handshake: tx_start is a one-cycle request taken only while tx_busy is low
// (including the tx_done cycle); requests while busy are dropped, not queued.
// tx_done pulses for one cycle with tx_busy already low.
module rfid_reader_pie_tx
  import rfid_reader_pie_tx_pkg::*;
#(
  parameter int DELIM_CYC = DELIM_CYC_DEF,
  parameter int PW_CYC    = PW_CYC_DEF,
  parameter int TARI_CYC  = TARI_CYC_DEF,
  parameter int RTCAL_CYC = RTCAL_CYC_DEF,
  parameter int TRCAL_CYC = TRCAL_CYC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tx_start,
  input  logic          tx_preamble,
  input  logic [6:0]    tx_len,
  input  logic [63:0]   tx_bits,
  input  logic          tx_abort,
  output logic          tx_busy,
  output logic          tx_done,
  output logic          tx_aborted,
  output logic          reader_modulation,
  output logic [2:0]    fsm_state
);

  pie_state_t       state_q, state_n;
  logic [6:0]       idx_q, idx_n, first_idx, idx_m1;
  logic [6:0]       len_q;
  logic [63:0]      bits_q;
  logic             pre_q;
  logic             busy_q, busy_n, done_q, done_n, aborted_q, aborted_n;
  logic             capture, finish;
  logic             t_load, t_low, t_force, sym_end;
  logic [CNT_W-1:0] t_len;

  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_aborted = aborted_q;
  assign fsm_state  = state_q;

  rfid_pie_symbol_timer #(.PW_CYC(PW_CYC)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (t_load),
    .load_len   (t_len),
    .load_low   (t_low),
    .force_high (t_force),
    .level      (reader_modulation),
    .sym_end    (sym_end)
  );

  // Sequence the symbols of a packet and pick the length of the next one.
  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    aborted_n = 1'b0;
    capture   = 1'b0;
    finish    = 1'b0;
    t_load    = 1'b0;
    t_len     = '0;
    t_low     = 1'b0;
    t_force   = 1'b0;
    first_idx = len_q - 7'd1;
    idx_m1    = idx_q - 7'd1;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        if (tx_start) begin
          capture = 1'b1;
          state_n = ST_DELIM;
          busy_n  = 1'b1;
          t_load  = 1'b1;
          t_len   = CNT_W'(DELIM_CYC);
          t_low   = 1'b1;
        end
      end
      ST_DELIM: if (sym_end) begin
        state_n = ST_DATA0;
        t_load  = 1'b1;
        t_len   = CNT_W'(TARI_CYC);
      end
      ST_DATA0: if (sym_end) begin
        state_n = ST_RTCAL;
        t_load  = 1'b1;
        t_len   = CNT_W'(RTCAL_CYC);
      end
      ST_RTCAL, ST_TRCAL: if (sym_end) begin
        if (state_q == ST_RTCAL && pre_q) begin
          state_n = ST_TRCAL;
          t_load  = 1'b1;
          t_len   = CNT_W'(TRCAL_CYC);
        end else if (len_q != 7'd0) begin
          state_n = ST_BITS;
          idx_n   = first_idx;
          t_load  = 1'b1;
          t_len   = bit_sym_len(bits_q[first_idx[5:0]], TARI_CYC, RTCAL_CYC);
        end else begin
          finish = 1'b1;
        end
      end
      ST_BITS: if (sym_end) begin
        if (idx_q == 7'd0) begin
          finish = 1'b1;
        end else begin
          idx_n  = idx_m1;
          t_load = 1'b1;
          t_len  = bit_sym_len(bits_q[idx_m1[5:0]], TARI_CYC, RTCAL_CYC);
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (finish) begin
      state_n = ST_DONE;
      t_force = 1'b1;
      done_n  = 1'b1;
      busy_n  = 1'b0;
    end
`ifdef PIE_TX_ABORT_EN
    // Abort only applies mid-packet, so a start in IDLE/DONE always wins.
    if (tx_abort && busy_q) begin
      state_n   = ST_IDLE;
      t_load    = 1'b0;
      t_force   = 1'b1;
      done_n    = 1'b1;
      aborted_n = 1'b1;
      busy_n    = 1'b0;
    end
`endif
  end

`ifndef PIE_TX_ABORT_EN
  logic unused_abort;
  assign unused_abort = tx_abort;
`endif

  // State, status flags and the captured packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      pre_q     <= 1'b0;
      len_q     <= '0;
      bits_q    <= '0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      aborted_q <= aborted_n;
      if (capture) begin
        pre_q  <= tx_preamble;
        len_q  <= (tx_len > 7'(MAX_BITS)) ? 7'(MAX_BITS) : tx_len;
        bits_q <= tx_bits;
      end
    end
  end

  // Symbol ordering relies on PW < Tari < RTCAL < TRCAL.
  always @(posedge clk) begin
    assert (PW_CYC < TARI_CYC && TARI_CYC < RTCAL_CYC && RTCAL_CYC < TRCAL_CYC);
  end

endmodule

// File: tb/tb_rfid_reader_pie_tx.sv
// Bench for rfid_reader_pie_tx: a symbol-list model expands each packet into
// the expected per-cycle modulation level, compared on falling edges.
// Honours PIE_TX_ABORT_EN the same way as the design.
module tb_rfid_reader_pie_tx;

  localparam int DELIM = 117;
  localparam int PW    = 8;
  localparam int TARI  = 49;
  localparam int RTCAL = 146;
  localparam int TRCAL = 195;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_start, tx_preamble, tx_abort;
  logic [6:0]  tx_len;
  logic [63:0] tx_bits;
  logic        tx_busy, tx_done, tx_aborted, reader_modulation;
  logic [2:0]  unused_fsm_state;

  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];

  rfid_reader_pie_tx dut (
    .clk               (clk),
    .reset             (reset),
    .tx_start          (tx_start),
    .tx_preamble       (tx_preamble),
    .tx_len            (tx_len),
    .tx_bits           (tx_bits),
    .tx_abort          (tx_abort),
    .tx_busy           (tx_busy),
    .tx_done           (tx_done),
    .tx_aborted        (tx_aborted),
    .reader_modulation (reader_modulation),
    .fsm_state         (unused_fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Model: list symbol lengths, then expand to levels (delimiter all low).
  task automatic build_expected(input logic pre, input int len, input logic [63:0] bits);
    int syms[$];
    int n;
    exp_q.delete();
    n = (len > 64) ? 64 : len;
    syms.push_back(TARI);
    syms.push_back(RTCAL);
    if (pre) syms.push_back(TRCAL);
    for (int i = n - 1; i >= 0; i--) syms.push_back(bits[i] ? (RTCAL - TARI) : TARI);
    for (int i = 0; i < DELIM; i++) exp_q.push_back(1'b0);
    foreach (syms[s]) begin
      for (int i = 0; i < syms[s] - PW; i++) exp_q.push_back(1'b1);
      for (int i = 0; i < PW; i++) exp_q.push_back(1'b0);
    end
  endtask

  // driver: called at a falling edge, returns at the falling edge of cycle 0
  task automatic drive_start(input logic pre, input logic [6:0] len, input logic [63:0] bits);
    tx_preamble = pre;
    tx_len      = len;
    tx_bits     = bits;
    tx_start    = 1'b1;
    @(negedge clk);
    tx_start    = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (reader_modulation !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL in_reset: mod=%b busy=%b done=%b, want 1 0 0", reader_modulation, tx_busy, tx_done);
    end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (reader_modulation !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_aborted !== 1'b0) begin
        errors++;
        $display("FAIL idle k=%0d: mod=%b busy=%b done=%b ab=%b, want 1 0 0 0",
                 k, reader_modulation, tx_busy, tx_done, tx_aborted);
      end
    end
  endtask

  task automatic test_preamble_only();
    build_expected(1'b1, 0, 64'd0);
    drive_start(1'b1, 7'd0, 64'd0);
    for (int k = 0; k <= exp_q.size(); k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (k < exp_q.size()) begin
        if (reader_modulation !== exp_q[k][0] || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
          errors++;
          $display("FAIL preamble k=%0d: mod=%b busy=%b done=%b, want mod=%b busy=1 done=0",
                   k, reader_modulation, tx_busy, tx_done, exp_q[k][0]);
        end
      end else if (reader_modulation !== 1'b1 || tx_done !== 1'b1 || tx_busy !== 1'b0 || tx_aborted !== 1'b0) begin
        errors++;
        $display("FAIL preamble_done k=%0d: mod=%b done=%b busy=%b ab=%b, want 1 1 0 0",
                 k, reader_modulation, tx_done, tx_busy, tx_aborted);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int seen;
    build_expected(1'b1, 0, 64'd0);
    drive_start(1'b1, 7'd0, 64'd0);
    for (int k = 0; k <= exp_q.size(); k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (k < exp_q.size()) begin
        if (reader_modulation !== exp_q[k][0] || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
          errors++;
          $display("FAIL ignore k=%0d: mod=%b busy=%b done=%b, want mod=%b busy=1 done=0",
                   k, reader_modulation, tx_busy, tx_done, exp_q[k][0]);
        end
      end else if (reader_modulation !== 1'b1 || tx_done !== 1'b1 || tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL ignore_done k=%0d: mod=%b done=%b busy=%b, want 1 1 0",
                 k, reader_modulation, tx_done, tx_busy);
      end
      tx_start = (k == 200);
    end
    // restart in the done cycle: frame-sync, no bits
    tx_preamble = 1'b0;
    tx_len      = 7'd0;
    tx_start    = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    checks++;
    if (tx_busy !== 1'b1 || reader_modulation !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL restart_on_done: busy=%b mod=%b done=%b, want 1 0 0", tx_busy, reader_modulation, tx_done);
    end
    seen = -1;
    for (int k = 1; k <= 400 && seen < 0; k++) begin
      @(negedge clk);
      if (tx_done === 1'b1) seen = k;
    end
    checks++;
    if (seen != DELIM + TARI + RTCAL) begin
      errors++;
      $display("FAIL restart_len: done at %0d, want %0d (-1 = timeout)", seen, DELIM + TARI + RTCAL);
    end
  endtask

  task automatic test_random_packets();
    logic        pre;
    int          len;
    logic [63:0] bits;
    for (int p = 0; p < 7; p++) begin
      if (p == 0) begin
        pre = 1'b0; len = 2; bits = 64'h2;
      end else begin
        pre  = 1'($urandom_range(0, 1));
        len  = $urandom_range(0, 20);
        bits = {$urandom, $urandom};
      end
      build_expected(pre, len, bits);
      drive_start(pre, 7'(len), bits);
      for (int k = 0; k <= exp_q.size(); k++) begin
        if (k > 0) @(negedge clk);
        checks++;
        if (k < exp_q.size()) begin
          if (reader_modulation !== exp_q[k][0] || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL pkt%0d k=%0d: mod=%b busy=%b done=%b, want mod=%b busy=1 done=0",
                     p, k, reader_modulation, tx_busy, tx_done, exp_q[k][0]);
          end
        end else if (reader_modulation !== 1'b1 || tx_done !== 1'b1 || tx_busy !== 1'b0) begin
          errors++;
          $display("FAIL pkt%0d_done k=%0d: mod=%b done=%b busy=%b, want 1 1 0",
                   p, k, reader_modulation, tx_done, tx_busy);
        end
      end
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
  endtask

  task automatic test_clamp();
    build_expected(1'b0, 100, {64{1'b1}});
    drive_start(1'b0, 7'd100, {64{1'b1}});
    for (int k = 0; k <= exp_q.size(); k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (k < exp_q.size()) begin
        if (reader_modulation !== exp_q[k][0] || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
          errors++;
          $display("FAIL clamp k=%0d: mod=%b busy=%b done=%b, want mod=%b busy=1 done=0",
                   k, reader_modulation, tx_busy, tx_done, exp_q[k][0]);
        end
      end else if (reader_modulation !== 1'b1 || tx_done !== 1'b1 || tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL clamp_done k=%0d: mod=%b done=%b busy=%b, want 1 1 0",
                 k, reader_modulation, tx_done, tx_busy);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    build_expected(1'b1, 3, {$urandom, $urandom});
    drive_start(1'b1, 7'd3, 64'h5);
    for (int k = 0; k <= 150; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (reader_modulation !== exp_q[k][0] || tx_busy !== 1'b1) begin
        errors++;
        $display("FAIL pre_reset k=%0d: mod=%b busy=%b, want mod=%b busy=1",
                 k, reader_modulation, tx_busy, exp_q[k][0]);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (reader_modulation !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: mod=%b busy=%b done=%b, want 1 0 0", reader_modulation, tx_busy, tx_done);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (tx_done !== 1'b0 || reader_modulation !== 1'b1 || tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset k=%0d: done=%b mod=%b busy=%b, want 0 1 0",
                 k, tx_done, reader_modulation, tx_busy);
      end
    end
  endtask

`ifdef PIE_TX_ABORT_EN
  task automatic test_abort();
    int seen;
    build_expected(1'b1, 4, 64'h9);
    drive_start(1'b1, 7'd4, 64'h9);
    for (int k = 0; k <= 150; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (reader_modulation !== exp_q[k][0] || tx_busy !== 1'b1) begin
        errors++;
        $display("FAIL pre_abort k=%0d: mod=%b busy=%b, want mod=%b busy=1",
                 k, reader_modulation, tx_busy, exp_q[k][0]);
      end
    end
    tx_abort = 1'b1;
    @(negedge clk);
    tx_abort = 1'b0;
    checks++;
    if (reader_modulation !== 1'b1 || tx_done !== 1'b1 || tx_aborted !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort: mod=%b done=%b ab=%b busy=%b, want 1 1 1 0",
               reader_modulation, tx_done, tx_aborted, tx_busy);
    end
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b0 || tx_aborted !== 1'b0 || reader_modulation !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: done=%b ab=%b mod=%b busy=%b, want 0 0 1 0",
               tx_done, tx_aborted, reader_modulation, tx_busy);
    end
    // abort together with start while idle: start wins
    tx_abort = 1'b1;
    drive_start(1'b0, 7'd0, 64'd0);
    tx_abort = 1'b0;
    checks++;
    if (tx_busy !== 1'b1 || reader_modulation !== 1'b0 || tx_aborted !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL start_wins: busy=%b mod=%b ab=%b done=%b, want 1 0 0 0",
               tx_busy, reader_modulation, tx_aborted, tx_done);
    end
    seen = -1;
    for (int k = 1; k <= 400 && seen < 0; k++) begin
      @(negedge clk);
      if (tx_done === 1'b1) seen = k;
    end
    checks++;
    if (seen != DELIM + TARI + RTCAL) begin
      errors++;
      $display("FAIL start_wins_len: done at %0d, want %0d (-1 = timeout)", seen, DELIM + TARI + RTCAL);
    end
    @(negedge clk);
  endtask
`else
  task automatic test_abort_ignored();
    build_expected(1'b0, 3, 64'h3);
    drive_start(1'b0, 7'd3, 64'h3);
    for (int k = 0; k <= exp_q.size(); k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (k < exp_q.size()) begin
        if (reader_modulation !== exp_q[k][0] || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
          errors++;
          $display("FAIL abort_ign k=%0d: mod=%b busy=%b done=%b, want mod=%b busy=1 done=0",
                   k, reader_modulation, tx_busy, tx_done, exp_q[k][0]);
        end
      end else if (reader_modulation !== 1'b1 || tx_done !== 1'b1 || tx_aborted !== 1'b0) begin
        errors++;
        $display("FAIL abort_ign_done k=%0d: mod=%b done=%b ab=%b, want 1 1 0",
                 k, reader_modulation, tx_done, tx_aborted);
      end
      tx_abort = (k >= 150 && k < 153);
    end
    tx_abort = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    reset       = 1'b1;
    tx_start    = 1'b0;
    tx_preamble = 1'b0;
    tx_abort    = 1'b0;
    tx_len      = 7'd0;
    tx_bits     = 64'd0;
    test_reset();
    test_preamble_only();
    @(negedge clk);
    test_busy_ignore();
    @(negedge clk);
    test_random_packets();
    test_clamp();
    test_async_reset();
`ifdef PIE_TX_ABORT_EN
    test_abort();
`else
    test_abort_ignored();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
